// File: rtl/draw_player_phys_if.sv
// vga_if: VGA pixel stream bundle shared by the drawing stages.
//   vcount/hcount : current pixel coordinates
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit pixel colour
// Modport "in" is used by a consumer of the stream, "out" by its producer.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player_phys.sv
// draw_player_phys: player sprite with per-frame walking/jumping physics,
// overlaid onto a passing VGA stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stepleft/stepright  : level move requests
//   stepjump            : level jump request (a rising edge starts a jump,
//                         releasing it during ascent cuts the jump short)
//   vga_in / vga_out    : pixel stream, output delayed by one clock
//   pos_x, pos_y        : sprite top-left position
//   on_ground, facing   : standing flag, facing direction (1 = right)
module draw_player_phys #(
    parameter int          HOR_PIXELS = 800,
    parameter int          VER_PIXELS = 600,
    parameter int          CHAR_W     = 32,
    parameter int          CHAR_H     = 48,
    parameter logic [11:0] CHAR_COL   = 12'h15a,
    parameter logic [11:0] EYE_COL    = 12'hfff,
    parameter int          MOVE_STEP  = 4,
    parameter int          JUMP_V0    = 16,
    parameter int          GRAVITY    = 1,
    parameter int          MAX_FALL   = 12,
    parameter int          X_MIN      = 0,
    parameter int          X_MAX      = HOR_PIXELS,
    parameter int          Y_MIN      = 0,
    parameter int          GROUND_Y   = VER_PIXELS - 20 - CHAR_H
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stepleft,
    input  logic        stepright,
    input  logic        stepjump,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        on_ground,
    output logic        facing
);

    // 13-bit working constants so sums never wrap.
    localparam logic [12:0] XLo   = 13'(X_MIN);
    localparam logic [12:0] XHi   = 13'(X_MAX - CHAR_W);
    localparam logic [12:0] YLo   = 13'(Y_MIN);
    localparam logic [12:0] YGnd  = 13'(GROUND_Y);
    localparam logic [12:0] Step  = 13'(MOVE_STEP);
    localparam logic [12:0] Grav  = 13'(GRAVITY);
    localparam logic [12:0] MaxV  = 13'(MAX_FALL);
    localparam logic [12:0] ChrW  = 13'(CHAR_W);
    localparam logic [12:0] ChrH  = 13'(CHAR_H);
    localparam logic [11:0] XRst  = 12'((X_MAX - CHAR_W) / 2);
    localparam logic [11:0] JumpV = 12'(JUMP_V0);

    typedef enum logic [1:0] {StGround, StRising, StFalling} state_t;

    state_t      state;
    logic [11:0] vel;
    logic        jump_prev;
    logic        frame_tick;
    logic [11:0] draw_x;
    logic [11:0] draw_y;
    logic        draw_facing;

    // Motion helpers.
    logic [12:0] x_right;
    logic        x_left_clamp;
    logic        x_right_clamp;
    logic        y_up_clamp;
    logic [12:0] y_down;
    logic [12:0] vel_inc;

    always_comb begin
        x_right       = {1'b0, pos_x} + Step;
        x_left_clamp  = {1'b0, pos_x} < (XLo + Step);
        x_right_clamp = x_right > XHi;
        y_up_clamp    = {1'b0, pos_y} < (YLo + {1'b0, vel});
        y_down        = {1'b0, pos_y} + {1'b0, vel};
        vel_inc       = {1'b0, vel} + Grav;
    end

    assign on_ground = (state == StGround);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x       <= XRst;
            pos_y       <= YGnd[11:0];
            state       <= StGround;
            vel         <= 12'd0;
            facing      <= 1'b1;
            jump_prev   <= 1'b1;
            draw_x      <= XRst;
            draw_y      <= YGnd[11:0];
            draw_facing <= 1'b1;
        end else if (frame_tick) begin
            // Drawing uses the position as it stood at the start of this frame.
            draw_x      <= pos_x;
            draw_y      <= pos_y;
            draw_facing <= facing;
            jump_prev   <= stepjump;

            if (stepleft && !stepright) begin
                pos_x  <= x_left_clamp ? XLo[11:0] : pos_x - Step[11:0];
                facing <= 1'b0;
            end else if (stepright && !stepleft) begin
                pos_x  <= x_right_clamp ? XHi[11:0] : x_right[11:0];
                facing <= 1'b1;
            end

            unique case (state)
                StGround: begin
                    if (stepjump && !jump_prev) begin
                        state <= StRising;
                        vel   <= JumpV;
                    end
                end
                StRising: begin
                    if (!stepjump) begin
                        // Jump cut: stop ascending without moving this frame.
                        vel   <= 12'd0;
                        state <= StFalling;
                    end else begin
                        pos_y <= y_up_clamp ? YLo[11:0] : pos_y - vel;
                        if ({1'b0, vel} > Grav) begin
                            vel <= vel - Grav[11:0];
                        end else begin
                            vel   <= 12'd0;
                            state <= StFalling;
                        end
                    end
                end
                StFalling: begin
                    if (y_down >= YGnd) begin
                        pos_y <= YGnd[11:0];
                        vel   <= 12'd0;
                        state <= StGround;
                    end else begin
                        pos_y <= y_down[11:0];
                        vel   <= (vel_inc > MaxV) ? MaxV[11:0] : vel_inc[11:0];
                    end
                end
                default: begin
                    state <= StGround;
                end
            endcase
        end
    end

    // Pixel overlay.
    logic [12:0] hc;
    logic [12:0] vc;
    logic [12:0] dx;
    logic [12:0] dy;
    logic [12:0] eye_x;
    logic        in_sprite;
    logic        in_eye;
    logic [11:0] rgb_nxt;

    always_comb begin
        hc        = {2'b00, vga_in.hcount};
        vc        = {2'b00, vga_in.vcount};
        dx        = {1'b0, draw_x};
        dy        = {1'b0, draw_y};
        eye_x     = draw_facing ? (dx + ChrW - 13'd8) : (dx + 13'd4);
        in_sprite = (hc >= dx) && (hc < dx + ChrW) && (vc >= dy) && (vc < dy + ChrH);
        in_eye    = (vc >= dy + 13'd8) && (vc < dy + 13'd12) &&
                    (hc >= eye_x) && (hc < eye_x + 13'd4);
        rgb_nxt   = vga_in.rgb;
        if (vga_in.hblnk || vga_in.vblnk) begin
            rgb_nxt = 12'h000;
        end else if (in_sprite) begin
            rgb_nxt = in_eye ? EYE_COL : CHAR_COL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.vcount <= 11'd0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= 11'd0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= 12'h000;
        end else begin
            vga_out.vcount <= vga_in.vcount;
            vga_out.vsync  <= vga_in.vsync;
            vga_out.vblnk  <= vga_in.vblnk;
            vga_out.hcount <= vga_in.hcount;
            vga_out.hsync  <= vga_in.hsync;
            vga_out.hblnk  <= vga_in.hblnk;
            vga_out.rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_player_phys.sv
// Directed bench for draw_player_phys. dut1 uses defaults (reset x = 384,
// ground y = 532); dut2 uses X_MAX = 44 so it resets at x = 6 with a right
// bound of 12, exercising both horizontal clamps.
module tb_draw_player_phys;

    logic        clk;
    logic        rst_n;
    logic        stepleft1, stepright1, stepjump1;
    logic        stepleft2, stepright2, stepjump2;
    logic [11:0] pos_x1, pos_y1, pos_x2, pos_y2;
    logic        on_ground1, facing1, on_ground2, facing2;

    int n_checks = 0;
    int n_pass   = 0;

    vga_if vga1_in ();
    vga_if vga1_out ();
    vga_if vga2_in ();
    vga_if vga2_out ();

    draw_player_phys dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .stepleft  (stepleft1),
        .stepright (stepright1),
        .stepjump  (stepjump1),
        .vga_in    (vga1_in),
        .vga_out   (vga1_out),
        .pos_x     (pos_x1),
        .pos_y     (pos_y1),
        .on_ground (on_ground1),
        .facing    (facing1)
    );

    draw_player_phys #(.X_MAX(44)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .stepleft  (stepleft2),
        .stepright (stepright2),
        .stepjump  (stepjump2),
        .vga_in    (vga2_in),
        .vga_out   (vga2_out),
        .pos_x     (pos_x2),
        .pos_y     (pos_y2),
        .on_ground (on_ground2),
        .facing    (facing2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_vga(input int hc, input int vc, input logic hs, input logic hb,
                           input logic [11:0] rgb);
        vga1_in.hcount = 11'(hc);
        vga1_in.vcount = 11'(vc);
        vga1_in.hsync  = hs;
        vga1_in.vsync  = 1'b0;
        vga1_in.hblnk  = hb;
        vga1_in.vblnk  = 1'b0;
        vga1_in.rgb    = rgb;
        vga2_in.hcount = 11'(hc);
        vga2_in.vcount = 11'(vc);
        vga2_in.hsync  = hs;
        vga2_in.vsync  = 1'b0;
        vga2_in.hblnk  = hb;
        vga2_in.vblnk  = 1'b0;
        vga2_in.rgb    = rgb;
    endtask

    // One frame: (0,0) pixel raises frame_tick, motion updates on the next edge.
    task automatic do_tick();
        @(negedge clk);
        set_vga(0, 0, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
        set_vga(100, 100, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Drive a pixel, then check the output one clock later.
    task automatic pixel(input string tag, input int which, input int hc, input int vc,
                         input logic hs, input logic hb, input logic [11:0] rgb_in,
                         input logic [11:0] exp_rgb);
        set_vga(hc, vc, hs, hb, rgb_in);
        @(negedge clk);
        if (which == 1) begin
            check({tag, "_rgb"}, vga1_out.rgb, exp_rgb);
            check({tag, "_hs"}, vga1_out.hsync, hs);
            check({tag, "_hc"}, vga1_out.hcount, hc);
        end else begin
            check({tag, "_rgb"}, vga2_out.rgb, exp_rgb);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        stepleft1  = 1'b0;
        stepright1 = 1'b0;
        stepjump1  = 1'b1;
        stepleft2  = 1'b0;
        stepright2 = 1'b0;
        stepjump2  = 1'b0;
        set_vga(100, 100, 1'b1, 1'b0, 12'h123);
        repeat (3) @(negedge clk);

        check("rst_pos_x1", pos_x1, 384);
        check("rst_pos_y1", pos_y1, 532);
        check("rst_ground1", on_ground1, 1);
        check("rst_facing1", facing1, 1);
        check("rst_pos_x2", pos_x2, 6);
        check("rst_out_rgb", vga1_out.rgb, 12'h000);
        check("rst_out_hs", vga1_out.hsync, 0);
        rst_n = 1'b1;

        // Sprite at (384,532), facing right: marker x 408..411, y 540..543.
        pixel("px_corner", 1, 384, 532, 1'b1, 1'b0, 12'h123, 12'h15a);
        pixel("px_eye", 1, 408, 540, 1'b0, 1'b0, 12'h123, 12'hfff);
        pixel("px_eye_left", 1, 407, 540, 1'b1, 1'b0, 12'h123, 12'h15a);
        pixel("px_bg", 1, 416, 532, 1'b0, 1'b0, 12'h123, 12'h123);
        pixel("px_last", 1, 415, 579, 1'b1, 1'b0, 12'h456, 12'h15a);
        pixel("px_below", 1, 415, 580, 1'b0, 1'b0, 12'h456, 12'h456);
        pixel("px_blank", 1, 408, 540, 1'b1, 1'b1, 12'h123, 12'h000);

        // Jump held through reset must not trigger.
        do_tick();
        check("held_no_jump", on_ground1, 1);
        check("held_pos_y", pos_y1, 532);

        // Left clamp on dut2.
        stepleft2 = 1'b1;
        do_tick();
        check("left_6_to_2", pos_x2, 2);
        check("left_facing", facing2, 0);
        do_tick();
        check("left_clamp0", pos_x2, 0);
        do_tick();
        check("left_stay0", pos_x2, 0);
        // Draw now latched at x=0 facing left: marker x 4..7, y 540..543.
        pixel("px2_eye", 2, 4, 540, 1'b0, 1'b0, 12'h321, 12'hfff);
        pixel("px2_body", 2, 3, 540, 1'b0, 1'b0, 12'h321, 12'h15a);
        pixel("px2_body_r", 2, 8, 540, 1'b0, 1'b0, 12'h321, 12'h15a);

        stepleft2  = 1'b0;
        stepright2 = 1'b1;
        do_tick();
        check("right_4", pos_x2, 4);
        check("right_facing", facing2, 1);
        ticks(2);
        check("right_12", pos_x2, 12);
        do_tick();
        check("right_clamp", pos_x2, 12);
        stepleft2 = 1'b1;
        do_tick();
        check("both_nochange", pos_x2, 12);
        check("both_facing", facing2, 1);
        stepleft2  = 1'b0;
        stepright2 = 1'b0;

        // Release, then press: jump begins with no position change.
        stepjump1 = 1'b0;
        do_tick();
        check("release_ground", on_ground1, 1);
        stepjump1 = 1'b1;
        do_tick();
        check("jump_start_gnd", on_ground1, 0);
        check("jump_start_y", pos_y1, 532);
        ticks(15);
        check("rise15_y", pos_y1, 397);
        do_tick();
        check("apex_y", pos_y1, 396);
        do_tick();
        check("fall_v0_y", pos_y1, 396);
        ticks(12);
        check("fall_ramp_y", pos_y1, 474);
        ticks(4);
        check("fall_term_y", pos_y1, 522);
        check("air_ground", on_ground1, 0);
        do_tick();
        check("land_y", pos_y1, 532);
        check("land_ground", on_ground1, 1);
        do_tick();
        check("held_land_gnd", on_ground1, 1);

        stepjump1 = 1'b0;
        do_tick();
        stepjump1 = 1'b1;
        do_tick();
        check("rejump_gnd", on_ground1, 0);
        ticks(6);
        check("rise6_y", pos_y1, 451);
        stepjump1 = 1'b0;
        do_tick();
        check("cut_y", pos_y1, 451);
        check("cut_gnd", on_ground1, 0);
        do_tick();
        check("cut_fall0_y", pos_y1, 451);
        do_tick();
        check("cut_fall1_y", pos_y1, 452);
        check("x1_untouched", pos_x1, 384);

        // Asynchronous reset while airborne.
        #2;
        rst_n = 1'b0;
        #1;
        check("midair_rst_y", pos_y1, 532);
        check("midair_rst_gnd", on_ground1, 1);
        check("midair_rst_x2", pos_x2, 6);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_player_phys.md
DRAW_PLAYER_PHYS -- requirements
Module: draw_player_phys

Interface
REQ-001 Parameter CHAR_W, default 32: sprite width in pixels.
REQ-002 Parameter CHAR_H, default 48: sprite height in pixels.
REQ-003 Parameter CHAR_COL, default 12'h15a: body colour.
REQ-004 Parameter EYE_COL, default 12'hfff: facing-marker colour.
REQ-005 Parameter MOVE_STEP, default 4: horizontal pixels per frame.
REQ-006 Parameter JUMP_V0, default 16: initial upward speed in pixels per frame.
REQ-007 Parameter GRAVITY, default 1: speed change per frame.
REQ-008 Parameter MAX_FALL, default 12: terminal fall speed.
REQ-009 Parameter X_MIN, default 0: leftmost legal pos_x.
REQ-010 Parameter X_MAX, default HOR_PIXELS: right screen bound; pos_x never exceeds X_MAX-CHAR_W.
REQ-011 Parameter Y_MIN, default 0: topmost legal pos_y.
REQ-012 Parameter GROUND_Y, default VER_PIXELS-20-CHAR_H: pos_y when standing.
REQ-013 Port clk, input, 1: single clock for all logic.
REQ-014 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-015 Port stepleft, input, 1: move-left request, level.
REQ-016 Port stepright, input, 1: move-right request, level.
REQ-017 Port stepjump, input, 1: jump request, level.
REQ-018 Port vga_in, vga_if.in: upstream timing and rgb.
REQ-019 Port vga_out, vga_if.out: timing delayed 1 cycle, rgb with sprite overlaid.
REQ-020 Port pos_x, output, 12: top-left x of sprite.
REQ-021 Port pos_y, output, 12: top-left y of sprite.
REQ-022 Port on_ground, output, 1: high in state GROUND.
REQ-023 Port facing, output, 1: 0 = left, 1 = right.

Function
REQ-024 frame_tick SHALL be a one-cycle pulse, registered once, on vga_in.hcount==0 && vga_in.vcount==0; all motion state updates only on frame_tick.
REQ-025 Horizontal: stepleft alone: pos_x -= MOVE_STEP, clamped to X_MIN, facing<=0; stepright alone: pos_x += MOVE_STEP, clamped to X_MAX-CHAR_W, facing<=1; both or neither: no change.
REQ-026 Vertical FSM states GROUND, RISING, FALLING; speed held in unsigned register vel, direction implied by state.
REQ-027 GROUND: on jump edge (stepjump==1 at this tick, 0 at previous tick) go RISING, vel<=JUMP_V0, pos_y unchanged this tick; held stepjump SHALL NOT retrigger.
REQ-028 RISING: pos_y -= vel, saturating at Y_MIN; if vel>GRAVITY then vel-=GRAVITY, else vel<=0 and go FALLING.
REQ-029 RISING with stepjump==0 (jump cut): no position update this tick, vel<=0, go FALLING.
REQ-030 FALLING: if pos_y+vel >= GROUND_Y then pos_y<=GROUND_Y, vel<=0, go GROUND; else pos_y+=vel, vel<=min(vel+GRAVITY, MAX_FALL).
REQ-031 Horizontal and vertical updates SHALL apply in the same frame_tick, independently.
REQ-032 Drawing SHALL use positions latched at frame_tick (draw_x, draw_y), so the sprite never tears mid-frame.
REQ-033 Pixel inside [draw_x, draw_x+CHAR_W-1] x [draw_y, draw_y+CHAR_H-1]: rgb = CHAR_COL, except the 4x4 marker rows draw_y+8..+11, columns draw_x+4..+7 (facing 0) or draw_x+CHAR_W-8..-5 (facing 1), which use EYE_COL.
REQ-034 Blanking (hblnk or vblnk) SHALL output rgb 12'h000; elsewhere outside sprite pass vga_in.rgb.
REQ-035 Latency: all vga_out fields are exactly 1 clk behind vga_in.
REQ-036 Arithmetic: 12-bit unsigned; comparisons computed without underflow (e.g. pos_x < X_MIN+MOVE_STEP rather than pos_x-MOVE_STEP).

Reset
REQ-037 rst_n low asynchronously: pos_x=(X_MAX-CHAR_W)/2, pos_y=GROUND_Y, state GROUND, vel=0, facing=1, jump-previous=1 (no jump until release), frame_tick=0, vga_out all fields 0.
REQ-038 Reset asserted mid-jump SHALL return immediately to the reset values above.

Verification
REQ-039 Jump from rest, stepjump held, defaults: tick1 RISING vel=16; after 16 more ticks pos_y=GROUND_Y-136, state FALLING, vel=0.
REQ-040 Fall from GROUND_Y-136: vel ramps 1..12 then stays 12; lands exactly at GROUND_Y, on_ground=1, no overshoot.
REQ-041 stepleft held from pos_x=6: next tick pos_x=2, following tick pos_x=0 (clamped), facing=0.
REQ-042 stepjump held through landing -> stays GROUND; release one tick then press -> RISING.
REQ-043 Release stepjump at vel=10 in RISING -> FALLING next tick, pos_y unchanged that tick.
REQ-044 Pixel check: known draw_x/draw_y, facing=1 -> EYE_COL at (draw_x+CHAR_W-8, draw_y+8), CHAR_COL at (draw_x, draw_y), background at (draw_x+CHAR_W, draw_y), 12'h000 in blanking, all 1 cycle late.
